// File: rtl/basic_pwm_if.sv
// Control-side bundle for basic_pwm: the requested duty and the PWM waveform.
interface basic_pwm_if #(
    parameter int unsigned R = 8
);
    logic [R-1:0] duty;
    logic         pwm_out;

    // Register/control side: supplies duty, observes the waveform.
    modport master (
        output duty,
        input  pwm_out
    );

    // PWM block side.
    modport slave (
        input  duty,
        output pwm_out
    );
endinterface

// File: rtl/basic_pwm.sv
// Free-running counter PWM. One period every 2^R cycles; the output is high
// for duty_act cycles at the start of each period. The requested duty is
// buffered and only adopted on the last cycle of a period, so a running
// period is never cut short or extended. pwm_out is registered and lags the
// counter by one cycle.
module basic_pwm #(
    parameter int unsigned R = 8
) (
    input  logic       clk,
    input  logic       reset_n,   // active-high synchronous reset despite the name
    basic_pwm_if.slave bus
);

    localparam logic [R-1:0] CNT_MAX = '1;
    localparam logic [R-1:0] CNT_ONE = {{(R-1){1'b0}}, 1'b1};

    logic [R-1:0] cnt_q, cnt_d;
    logic [R-1:0] duty_act_q, duty_act_d;
    logic         pwm_q, pwm_d;

    // Next-state: wrap-around count, boundary-only duty load, compare for output.
    always_comb begin
        cnt_d      = cnt_q + CNT_ONE;
        duty_act_d = (cnt_q == CNT_MAX) ? bus.duty : duty_act_q;
        pwm_d      = (cnt_q < duty_act_q);
    end

    // State registers; reset restarts the period with an all-low duty.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign bus.pwm_out = pwm_q;

endmodule

// File: tb/tb_basic_pwm.sv
// Bench for basic_pwm at R=8 and R=4. A period-level model (list of duty
// values per period, indexed by cycles since reset) predicts every output
// cycle; directed scenarios add literal per-period high counts and shape checks.
module tb_basic_pwm;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst4 = 1'b1;

    basic_pwm_if #(.R(8)) bus8 ();
    basic_pwm_if #(.R(4)) bus4 ();

    basic_pwm #(.R(8)) u_pwm8 (.clk(clk), .reset_n(rst8), .bus(bus8));
    basic_pwm #(.R(4)) u_pwm4 (.clk(clk), .reset_n(rst4), .bus(bus4));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: n = non-reset edges since reset; pd[k] = duty governing period k.
    // Output after edge n reflects position (n-1) mod P of period (n-1)/P.
    // Inputs only change 1 time unit after a falling edge, so values read at
    // the falling edge are those the DUT sampled at the preceding rising edge.
    int  n8, n4;
    int  pd8[$];
    int  pd4[$];

    initial begin
        int  e;
        forever begin
            @(negedge clk);
            if (rst8) begin
                n8 = 0; pd8.delete(); pd8.push_back(0); e = 0;
            end else begin
                if (n8 % 256 == 255) pd8.push_back(int'(bus8.duty));
                n8++;
                e = (((n8 - 1) % 256) < pd8[(n8 - 1) / 256]) ? 1 : 0;
            end
            n_cmp++;
            if (int'(bus8.pwm_out) != e) begin
                n_bad++;
                $display("FAIL cycle8 n=%0d: got %0d expected %0d", n8, bus8.pwm_out, e);
            end
        end
    end

    initial begin
        int  e;
        forever begin
            @(negedge clk);
            if (rst4) begin
                n4 = 0; pd4.delete(); pd4.push_back(0); e = 0;
            end else begin
                if (n4 % 16 == 15) pd4.push_back(int'(bus4.duty));
                n4++;
                e = (((n4 - 1) % 16) < pd4[(n4 - 1) / 16]) ? 1 : 0;
            end
            n_cmp++;
            if (int'(bus4.pwm_out) != e) begin
                n_bad++;
                $display("FAIL cycle4 n=%0d: got %0d expected %0d", n4, bus4.pwm_out, e);
            end
        end
    end

    task automatic set_duty(input int which, input int d);
        if (which == 8) bus8.duty = 8'(d);
        else            bus4.duty = 4'(d);
    endtask

    function automatic int pwm_of(input int which);
        return (which == 8) ? int'(bus8.pwm_out) : int'(bus4.pwm_out);
    endfunction

    // Hold reset for `cycles` rising edges with duty preset; the next rising
    // edge after return is the first counting edge.
    task automatic do_reset(input int which, input int d, input int cycles);
        @(negedge clk); #1;
        if (which == 8) rst8 = 1'b1; else rst4 = 1'b1;
        set_duty(which, d);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("reset_low", pwm_of(which), 0);
        end
        #1;
        if (which == 8) rst8 = 1'b0; else rst4 = 1'b0;
    endtask

    // Observe one output period; optionally change duty after sample chg_i
    // (the counter then holds chg_i+1). Shape must be one leading high run.
    task automatic measure(input int which, input int chg_i, input int new_duty,
                           output int hi, output int shape_ok);
        int P;
        int s[256];
        P = (which == 8) ? 256 : 16;
        hi = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            s[i] = pwm_of(which);
            hi += s[i];
            if (i == chg_i) begin
                #1;
                set_duty(which, new_duty);
            end
        end
        shape_ok = 1;
        for (int i = 0; i < P; i++)
            if (s[i] != ((i < hi) ? 1 : 0)) shape_ok = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, ok, exp_cur, nd, ci;
        bus8.duty = '0;
        bus4.duty = '0;
        repeat (3) @(negedge clk);
        rst4 = 1'b1;

        // 1: duty 171 after reset
        do_reset(8, 171, 2);
        measure(8, -1, 0, hi, ok);   chk("t1_p0_hi", hi, 0);
        measure(8, -1, 0, hi, ok);   chk("t1_p1_hi", hi, 171); chk("t1_p1_shape", ok, 1);
        measure(8, -1, 0, hi, ok);   chk("t1_p2_hi", hi, 171);

        // 2: duty 0 for three periods, then duty 255
        do_reset(8, 0, 2);
        for (int p = 0; p < 3; p++) begin
            measure(8, -1, 0, hi, ok); chk("t2_zero_hi", hi, 0);
        end
        do_reset(8, 255, 2);
        measure(8, -1, 0, hi, ok);   chk("t2_max_p0_hi", hi, 0);
        measure(8, -1, 0, hi, ok);   chk("t2_max_p1_hi", hi, 255); chk("t2_max_shape", ok, 1);
        measure(8, -1, 0, hi, ok);   chk("t2_max_p2_hi", hi, 255);

        // 3: duty 64, changed to 200 mid-period at cnt=100
        do_reset(8, 64, 2);
        measure(8, -1, 0, hi, ok);   chk("t3_p0_hi", hi, 0);
        measure(8, -1, 0, hi, ok);   chk("t3_p1_hi", hi, 64);
        measure(8, 99, 200, hi, ok); chk("t3_p2_hi", hi, 64);  chk("t3_p2_shape", ok, 1);
        measure(8, -1, 0, hi, ok);   chk("t3_p3_hi", hi, 200); chk("t3_p3_shape", ok, 1);

        // 4: reset pulse at cnt=50 while the output is high
        do_reset(8, 128, 2);
        measure(8, -1, 0, hi, ok);   chk("t4_p0_hi", hi, 0);
        repeat (50) @(negedge clk);
        chk("t4_high_before_rst", pwm_of(8), 1);
        #1 rst8 = 1'b1;
        @(negedge clk);
        chk("t4_low_after_rst", pwm_of(8), 0);
        #1 rst8 = 1'b0;
        measure(8, -1, 0, hi, ok);   chk("t4_r_p0_hi", hi, 0);
        measure(8, -1, 0, hi, ok);   chk("t4_r_p1_hi", hi, 128); chk("t4_r_p1_shape", ok, 1);

        // 5: R=4, duty 1 then 15 presented on the cnt=15 edge
        do_reset(4, 1, 2);
        measure(4, -1, 0, hi, ok);   chk("t5_p0_hi", hi, 0);
        measure(4, 14, 15, hi, ok);  chk("t5_p1_hi", hi, 1);  chk("t5_p1_shape", ok, 1);
        measure(4, -1, 0, hi, ok);   chk("t5_p2_hi", hi, 15); chk("t5_p2_shape", ok, 1);
        measure(4, -1, 0, hi, ok);   chk("t5_p3_hi", hi, 15);

        // 6: random duty updates over 50 periods
        do_reset(8, $urandom_range(0, 255), 2);
        exp_cur = 0;
        for (int p = 0; p < 50; p++) begin
            nd = $urandom_range(0, 255);
            ci = $urandom_range(0, 254);
            measure(8, ci, nd, hi, ok);
            chk("t6_hi", hi, exp_cur);
            chk("t6_shape", ok, 1);
            exp_cur = nd;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/basic_pwm.md
Name: basic_pwm

Overview:
Free-running, counter-based pulse-width modulator with R-bit duty resolution.
Produces one PWM period every 2^R clock cycles; the output is high for `duty` cycles of each period.
The duty input is double-buffered and takes effect only at a period boundary, so periods are never truncated or glitched.
The output is registered. The block sits between a register/control interface that supplies `duty` and an output pad or driver.

Parameters:
R, 8, duty/counter resolution in bits; legal R >= 2; period = 2^R clock cycles.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  synchronous reset, active-high: asserted when 1, sampled on the rising clk edge. The name follows codebase convention; the polarity is high.
duty  input  R  requested high time per period in clock cycles, unsigned, 0..2^R-1.
pwm_out  output  1  registered PWM waveform.

Behaviour:
- State: period counter cnt (R bits), active duty register duty_act (R bits), output register pwm_out.
- Reset: on any rising edge with reset_n=1, set cnt=0, duty_act=0 and pwm_out=0. Reset takes priority over all other updates, including mid-period; the period restarts cleanly.
- Counter:
  - Each non-reset edge, cnt <= cnt+1 modulo 2^R.
  - Wraps from 2^R-1 to 0 with no stall.
- Duty buffering:
  - On a non-reset edge where cnt == 2^R-1, duty_act <= duty. The new value governs the next period, starting at cnt=0.
  - `duty` changes at any other time are ignored until the next period boundary.
  - The first period after reset uses duty_act=0, so the output is low for 2^R cycles.
- Output:
  - Each non-reset edge, pwm_out <= (cnt < duty_act), an unsigned R-bit compare using the pre-edge values of cnt and duty_act.
  - The output therefore lags the counter by exactly one cycle.
  - Each period of pwm_out is one contiguous high run of duty_act cycles followed by 2^R - duty_act low cycles.
- Boundaries:
  - duty_act=0: pwm_out stays low for the whole period.
  - duty_act=2^R-1: high for 2^R-1 cycles, low for 1 cycle. 100% duty is not reachable, by design.
  - duty_act=1: a single-cycle high pulse per period.
- Duty change at the boundary:
  - If duty changes on the same edge where cnt == 2^R-1, the value sampled at that edge is loaded.
  - No partial periods, double pulses or runt pulses may occur.
- No combinational path from any input to pwm_out.
- Latency:
  - Deassert reset at edge E0. The first edge with reset_n=0 is E1, where cnt goes 0→1.
  - The duty present at edge E(2^R), when cnt == 2^R-1, is loaded into duty_act.
  - That duty first affects pwm_out at edge E(2^R+1).

Test Plan:
1. R=8. Hold reset_n=1 for 2 cycles, then release with duty=171.
   - pwm_out=0 during reset and for the entire first 256-cycle period.
   - Every later period: exactly 171 consecutive high cycles, then 85 low cycles.
2. R=8. duty=0 steady after reset → pwm_out never goes high over 3 full periods. duty=255 steady → each period has 255 high cycles and exactly 1 low cycle.
3. R=8. duty=64, then change to 200 at cnt=100 mid-period.
   - The current period keeps 64 high / 192 low.
   - The next period is 200 high / 56 low, with no runt pulse.
4. R=8. duty=128 steady. Assert reset_n for 1 cycle mid-period, at cnt=50, while pwm_out=1.
   - pwm_out=0 on the next edge.
   - The counter restarts at 0.
   - The next period is all low (duty_act=0); the one after it is 128 high / 128 low.
5. R=4. duty=1, then change to 15 exactly on the cnt=15 edge.
   - Confirm 16-cycle periods.
   - The change loads at that boundary.
   - Output pattern: a 1-cycle pulse, then 15 high / 1 low.
6. Randomised duty updates over 50 periods (R=8). A scoreboard checks every period's high count against the duty sampled at the preceding boundary, and checks that the period is exactly 256 cycles.
